fetch_prefetch_unit: RTL and testbench



---
 rtl/fetch_prefetch_unit.sv | 127 ++++++++++++
 tb/tb_fetch_prefetch_unit.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_prefetch_unit.sv
// Instruction-fetch front end: credit-limited sequential fetch into an in-order
// prefetch queue, with redirect flush and in-flight response dropping.
module fetch_prefetch_unit #(
  parameter int unsigned    XLEN        = 32,
  parameter int unsigned    DATA_W      = 32,
  parameter logic [XLEN-1:0] RESET_PC   = '0,
  parameter int unsigned    QUEUE_DEPTH = 4
) (
  input  logic              i_clk,
  input  logic              i_rstn,
  input  logic              i_redirect,
  input  logic [XLEN-1:0]   i_redirect_pc,
  output logic              o_imem_req_valid,
  input  logic              i_imem_req_ready,
  output logic [XLEN-1:0]   o_imem_req_addr,
  input  logic              i_imem_rsp_valid,
  input  logic [DATA_W-1:0] i_imem_rsp_data,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [XLEN-1:0]   o_pc,
  output logic [DATA_W-1:0] o_instr,
  output logic              o_fetch_err
);

  localparam int unsigned AW = $clog2(QUEUE_DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [XLEN-1:0]   r_q_pc   [QUEUE_DEPTH];
  logic [DATA_W-1:0] r_q_data [QUEUE_DEPTH];
  logic [AW-1:0]     r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]     r_count, r_outstanding, r_drop_cnt;
  logic [XLEN-1:0]   r_fetch_pc, r_rsp_pc;
  logic              r_fetch_err;

  logic [AW-1:0]     w_wr_ptr_nxt, w_rd_ptr_nxt;
  logic [CW-1:0]     w_count_nxt, w_outstanding_nxt, w_drop_cnt_nxt;
  logic [XLEN-1:0]   w_fetch_pc_nxt, w_rsp_pc_nxt;
  logic              w_fetch_err_nxt;
  logic [CW:0]       w_credit_used;
  logic              w_req_fire, w_push, w_pop;

  // Queue entries plus in-flight requests never exceed the queue depth.
  assign w_credit_used    = {1'b0, r_count} + {1'b0, r_outstanding};
  assign o_imem_req_valid = i_rstn & ~i_redirect & ~r_fetch_err &
                            (w_credit_used < (CW+1)'(QUEUE_DEPTH));
  assign o_imem_req_addr  = r_fetch_pc;
  assign w_req_fire       = o_imem_req_valid & i_imem_req_ready;

  assign o_valid     = (r_count != '0) & ~i_redirect;
  assign o_pc        = r_q_pc[r_rd_ptr];
  assign o_instr     = r_q_data[r_rd_ptr];
  assign o_fetch_err = r_fetch_err;
  assign w_pop       = o_valid & i_ready;
  assign w_push      = i_imem_rsp_valid & ~i_redirect & (r_drop_cnt == '0);

  // Next-state: redirect overrides all normal fetch/queue activity.
  always_comb begin
    w_wr_ptr_nxt      = r_wr_ptr;
    w_rd_ptr_nxt      = r_rd_ptr;
    w_count_nxt       = r_count;
    w_outstanding_nxt = r_outstanding;
    w_drop_cnt_nxt    = r_drop_cnt;
    w_fetch_pc_nxt    = r_fetch_pc;
    w_rsp_pc_nxt      = r_rsp_pc;
    w_fetch_err_nxt   = r_fetch_err;
    if (i_redirect) begin
      w_wr_ptr_nxt      = '0;
      w_rd_ptr_nxt      = '0;
      w_count_nxt       = '0;
      w_outstanding_nxt = r_outstanding - CW'(i_imem_rsp_valid);
      w_drop_cnt_nxt    = r_outstanding - CW'(i_imem_rsp_valid);
      w_fetch_pc_nxt    = i_redirect_pc;
      w_rsp_pc_nxt      = i_redirect_pc;
      w_fetch_err_nxt   = |i_redirect_pc[1:0];
    end else begin
      w_outstanding_nxt = r_outstanding + CW'(w_req_fire) - CW'(i_imem_rsp_valid);
      w_count_nxt       = r_count + CW'(w_push) - CW'(w_pop);
      if (w_req_fire) begin
        w_fetch_pc_nxt = r_fetch_pc + XLEN'(4);
      end
      if (i_imem_rsp_valid && (r_drop_cnt != '0)) begin
        w_drop_cnt_nxt = r_drop_cnt - CW'(1);
      end
      if (w_push) begin
        w_rsp_pc_nxt = r_rsp_pc + XLEN'(4);
        w_wr_ptr_nxt = r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        w_rd_ptr_nxt = r_rd_ptr + AW'(1);
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_count       <= '0;
      r_outstanding <= '0;
      r_drop_cnt    <= '0;
      r_fetch_pc    <= RESET_PC;
      r_rsp_pc      <= RESET_PC;
      r_fetch_err   <= 1'b0;
    end else begin
      r_wr_ptr      <= w_wr_ptr_nxt;
      r_rd_ptr      <= w_rd_ptr_nxt;
      r_count       <= w_count_nxt;
      r_outstanding <= w_outstanding_nxt;
      r_drop_cnt    <= w_drop_cnt_nxt;
      r_fetch_pc    <= w_fetch_pc_nxt;
      r_rsp_pc      <= w_rsp_pc_nxt;
      r_fetch_err   <= w_fetch_err_nxt;
    end
  end

  // Queue storage needs no reset; occupancy gates visibility.
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_q_pc[r_wr_ptr]   <= r_rsp_pc;
      r_q_data[r_wr_ptr] <= i_imem_rsp_data;
    end
  end

  a_rsp_has_request: assert property (@(posedge i_clk) disable iff (!i_rstn)
    i_imem_rsp_valid |-> (r_outstanding != '0));

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// Directed bench for fetch_prefetch_unit with a fixed-latency in-order memory model.
module tb_fetch_prefetch_unit;

  logic        clk = 1'b0;
  logic        rstn = 1'b1;
  logic        i_redirect = 1'b0;
  logic [31:0] i_redirect_pc = '0;
  logic        o_imem_req_valid;
  logic        i_imem_req_ready = 1'b1;
  logic [31:0] o_imem_req_addr;
  logic        i_imem_rsp_valid = 1'b0;
  logic [31:0] i_imem_rsp_data = '0;
  logic        o_valid;
  logic        i_ready = 1'b1;
  logic [31:0] o_pc;
  logic [31:0] o_instr;
  logic        o_fetch_err;

  int n_chk = 0;
  int n_fail = 0;
  int n_req = 0;
  int cyc = 0;
  int lat = 1;
  logic [31:0] mq_addr[$];
  int          mq_due[$];
  logic [31:0] obs_q[$];

  always #5 clk = ~clk;

  fetch_prefetch_unit #(.XLEN(32), .DATA_W(32), .RESET_PC(32'h0), .QUEUE_DEPTH(4)) dut (
    .i_clk(clk), .i_rstn(rstn), .i_redirect(i_redirect), .i_redirect_pc(i_redirect_pc),
    .o_imem_req_valid(o_imem_req_valid), .i_imem_req_ready(i_imem_req_ready),
    .o_imem_req_addr(o_imem_req_addr), .i_imem_rsp_valid(i_imem_rsp_valid),
    .i_imem_rsp_data(i_imem_rsp_data), .o_valid(o_valid), .i_ready(i_ready),
    .o_pc(o_pc), .o_instr(o_instr), .o_fetch_err(o_fetch_err)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'h1357_9BDF ^ (a >> 2);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Memory: accept on handshake, answer in order after lat cycles.
  always @(negedge clk) begin
    if (!rstn) begin
      mq_addr.delete();
      mq_due.delete();
    end else if (o_imem_req_valid && i_imem_req_ready) begin
      mq_addr.push_back(o_imem_req_addr);
      mq_due.push_back(cyc + lat);
      n_req++;
    end
  end

  always @(posedge clk) begin
    cyc++;
    #1;
    if (!rstn || mq_due.size() == 0 || mq_due[0] > cyc) begin
      i_imem_rsp_valid = 1'b0;
    end else begin
      i_imem_rsp_valid = 1'b1;
      i_imem_rsp_data  = mem_word(mq_addr.pop_front());
      void'(mq_due.pop_front());
    end
  end

  // Record every accepted instruction and check it against memory contents.
  always @(negedge clk) begin
    if (rstn && o_valid && i_ready) begin
      obs_q.push_back(o_pc);
      chk("instr_vs_mem", o_instr, mem_word(o_pc));
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench at the start of cycle 0 after reset release.
  task automatic do_reset();
    next_cycle();
    rstn = 1'b0;
    i_redirect = 1'b0;
    #1;
    chk("rst_o_valid", 32'(o_valid), 32'd0);
    chk("rst_req_valid", 32'(o_imem_req_valid), 32'd0);
    chk("rst_fetch_err", 32'(o_fetch_err), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    rstn = 1'b1;
  endtask

  task automatic check_obs(input string name, input int idx, input logic [31:0] exp);
    if (obs_q.size() <= idx) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s[%0d]: got no instruction, expected pc %h", name, idx, exp);
    end else begin
      chk($sformatf("%s[%0d]", name, idx), obs_q[idx], exp);
    end
  endtask

  typedef struct {
    logic        ready;
    logic        redir;
    logic [31:0] redir_pc;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic        exp_valid;
    logic [31:0] exp_pc;
  } vec_t;

  vec_t vecs[15];

  initial begin
    // Streaming, decode stall filling the queue, drain, then redirect
    // in the cycle a response arrives and decode would pop.
    vecs[0]  = '{1'b1, 1'b0, 32'h0,  1'b1, 32'h00, 1'b0, 32'h0};
    vecs[1]  = '{1'b1, 1'b0, 32'h0,  1'b1, 32'h04, 1'b0, 32'h0};
    vecs[2]  = '{1'b1, 1'b0, 32'h0,  1'b1, 32'h08, 1'b1, 32'h00};
    vecs[3]  = '{1'b1, 1'b0, 32'h0,  1'b1, 32'h0C, 1'b1, 32'h04};
    vecs[4]  = '{1'b0, 1'b0, 32'h0,  1'b1, 32'h10, 1'b1, 32'h08};
    vecs[5]  = '{1'b0, 1'b0, 32'h0,  1'b1, 32'h14, 1'b1, 32'h08};
    vecs[6]  = '{1'b0, 1'b0, 32'h0,  1'b0, 32'h0,  1'b1, 32'h08};
    vecs[7]  = '{1'b0, 1'b0, 32'h0,  1'b0, 32'h0,  1'b1, 32'h08};
    vecs[8]  = '{1'b1, 1'b0, 32'h0,  1'b0, 32'h0,  1'b1, 32'h08};
    vecs[9]  = '{1'b1, 1'b0, 32'h0,  1'b1, 32'h18, 1'b1, 32'h0C};
    vecs[10] = '{1'b1, 1'b0, 32'h0,  1'b1, 32'h1C, 1'b1, 32'h10};
    vecs[11] = '{1'b1, 1'b1, 32'h40, 1'b0, 32'h0,  1'b0, 32'h0};
    vecs[12] = '{1'b1, 1'b0, 32'h0,  1'b1, 32'h40, 1'b0, 32'h0};
    vecs[13] = '{1'b1, 1'b0, 32'h0,  1'b1, 32'h44, 1'b0, 32'h0};
    vecs[14] = '{1'b1, 1'b0, 32'h0,  1'b1, 32'h48, 1'b1, 32'h40};

    lat = 1;
    i_imem_req_ready = 1'b1;
    do_reset();
    for (int i = 0; i < 15; i++) begin
      i_ready       = vecs[i].ready;
      i_redirect    = vecs[i].redir;
      i_redirect_pc = vecs[i].redir_pc;
      @(negedge clk);
      chk($sformatf("v%0d_req_valid", i), 32'(o_imem_req_valid), 32'(vecs[i].exp_req));
      if (vecs[i].exp_req) chk($sformatf("v%0d_req_addr", i), o_imem_req_addr, vecs[i].exp_addr);
      chk($sformatf("v%0d_o_valid", i), 32'(o_valid), 32'(vecs[i].exp_valid));
      if (vecs[i].exp_valid) chk($sformatf("v%0d_o_pc", i), o_pc, vecs[i].exp_pc);
      next_cycle();
    end
    i_redirect = 1'b0;

    // Decode stalled from reset: exactly QUEUE_DEPTH requests, then drain in order.
    i_ready = 1'b0;
    do_reset();
    n_req = 0;
    repeat (10) next_cycle();
    @(negedge clk);
    chk("stall_req_count", 32'(n_req), 32'd4);
    chk("stall_req_valid", 32'(o_imem_req_valid), 32'd0);
    chk("stall_o_pc", o_pc, 32'h0);
    next_cycle();
    obs_q.delete();
    i_ready = 1'b1;
    repeat (8) next_cycle();
    for (int i = 0; i < 4; i++) check_obs("drain", i, 32'(4 * i));
    chk("resume_fetch", 32'(n_req > 4), 32'd1);

    // Redirect with two requests in flight on a 3-cycle memory.
    lat = 3;
    do_reset();
    @(negedge clk);
    chk("lat3_c0_addr", o_imem_req_addr, 32'h0);
    next_cycle();
    @(negedge clk);
    chk("lat3_c1_addr", o_imem_req_addr, 32'h4);
    next_cycle();
    i_redirect = 1'b1;
    i_redirect_pc = 32'h100;
    @(negedge clk);
    chk("redir_req_valid", 32'(o_imem_req_valid), 32'd0);
    next_cycle();
    i_redirect = 1'b0;
    obs_q.delete();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("drop_o_valid_%0d", i), 32'(o_valid), 32'd0);
      next_cycle();
    end
    repeat (8) next_cycle();
    for (int i = 0; i < 4; i++) check_obs("after_redir", i, 32'h100 + 32'(4 * i));

    // Misaligned redirect: sticky error, no fetch, until an aligned redirect.
    lat = 1;
    i_redirect = 1'b1;
    i_redirect_pc = 32'h102;
    next_cycle();
    i_redirect = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk($sformatf("err_flag_%0d", i), 32'(o_fetch_err), 32'd1);
      chk($sformatf("err_req_valid_%0d", i), 32'(o_imem_req_valid), 32'd0);
      chk($sformatf("err_o_valid_%0d", i), 32'(o_valid), 32'd0);
      next_cycle();
    end
    i_redirect = 1'b1;
    i_redirect_pc = 32'h200;
    next_cycle();
    i_redirect = 1'b0;
    obs_q.delete();
    @(negedge clk);
    chk("err_cleared", 32'(o_fetch_err), 32'd0);
    chk("err_resume_req", 32'(o_imem_req_valid), 32'd1);
    chk("err_resume_addr", o_imem_req_addr, 32'h200);
    repeat (6) next_cycle();
    check_obs("err_resume", 0, 32'h200);
    check_obs("err_resume", 1, 32'h204);

    // PC wrap with a randomly stalling memory request port.
    i_redirect = 1'b1;
    i_redirect_pc = 32'hFFFF_FFF8;
    next_cycle();
    i_redirect = 1'b0;
    obs_q.delete();
    for (int i = 0; i < 40; i++) begin
      i_imem_req_ready = 1'($urandom_range(0, 1));
      next_cycle();
    end
    i_imem_req_ready = 1'b1;
    repeat (6) next_cycle();
    check_obs("wrap", 0, 32'hFFFF_FFF8);
    check_obs("wrap", 1, 32'hFFFF_FFFC);
    check_obs("wrap", 2, 32'h0000_0000);
    check_obs("wrap", 3, 32'h0000_0004);
    check_obs("wrap", 4, 32'h0000_0008);
    check_obs("wrap", 5, 32'h0000_000C);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
